// File: rtl/sobel_stream_locked.sv
// Streaming 3x3 Sobel edge detector with ap_start/ap_done control and key gating.
// A wrong working key replaces edge data with the window centre XOR the key difference.
module sobel_stream_locked #(
  parameter int unsigned      IMG_W = 512,
  parameter int unsigned      IMG_H = 512,
  parameter int unsigned      PIX_W = 8,
  parameter int unsigned      KEY_W = 8,
  parameter logic [KEY_W-1:0] KEY   = KEY_W'(8'hA5)
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             ap_start,
  output logic             ap_done,
  output logic             ap_idle,
  output logic             ap_ready,
  input  logic [KEY_W-1:0] working_key,
  input  logic             mode,
  input  logic             invert,
  input  logic [PIX_W-1:0] in_pix,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned SW = PIX_W + 4;
  localparam logic [PIX_W-1:0] PMAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                    state;
  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic [KEY_W-1:0]          key_diff;
  logic                      mode_q;
  logic                      invert_q;
  logic [2:0][1:0][PIX_W-1:0] win;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] tap0, tap1;

  logic [2:0][2:0][PIX_W-1:0] p;
  logic signed [SW-1:0]       gx, gy;
  logic [SW-1:0]              ax, ay, mag_raw;
  logic [PIX_W-1:0]           mag, edge_pix, out_next;
  logic                       xfer, load, last;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] v);
    return $signed({4'b0000, v});
  endfunction

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign xfer     = in_valid && in_ready;
  assign load     = xfer && (row >= RW'(2)) && (col >= CW'(2));
  assign last     = (row == RW'(IMG_H - 1)) && (col == CW'(IMG_W - 1));

  assign ap_idle  = (state == IDLE);
  assign ap_done  = (state == DONE);
  assign ap_ready = ap_done;

  // Line buffers: lb0 holds the previous row, lb1 the row before it.
  assign tap0 = lb0[col];
  assign tap1 = lb1[col];

  always_ff @(posedge ap_clk) begin
    if (xfer) begin
      lb0[col] <= in_pix;
      lb1[col] <= tap0;
    end
  end

  // Window as it will look after this transfer: stored two columns plus the new column.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      p[r][0] = win[r][0];
      p[r][1] = win[r][1];
    end
    p[0][2] = tap1;
    p[1][2] = tap0;
    p[2][2] = in_pix;
  end

  always_comb begin
    gx = ext(p[0][2]) + (ext(p[1][2]) <<< 1) + ext(p[2][2])
       - ext(p[0][0]) - (ext(p[1][0]) <<< 1) - ext(p[2][0]);
    gy = ext(p[2][0]) + (ext(p[2][1]) <<< 1) + ext(p[2][2])
       - ext(p[0][0]) - (ext(p[0][1]) <<< 1) - ext(p[0][2]);
    ax = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    ay = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag_raw = mode_q ? ((ax > ay) ? ax : ay) : (ax + ay);
    mag = (mag_raw > SW'(PMAX)) ? PMAX : mag_raw[PIX_W-1:0];
    edge_pix = invert_q ? (PMAX - mag) : mag;
    out_next = (key_diff != '0) ? (p[1][1] ^ PIX_W'(key_diff)) : edge_pix;
  end

  // Control FSM, pixel counters, window and output register.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      row       <= '0;
      col       <= '0;
      key_diff  <= '0;
      mode_q    <= 1'b0;
      invert_q  <= 1'b0;
      win       <= '0;
      out_valid <= 1'b0;
      out_pix   <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_pix   <= out_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (xfer) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= p[r][2];
        end
        if (col == CW'(IMG_W - 1)) begin
          col <= '0;
          row <= last ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      case (state)
        IDLE: begin
          if (ap_start) begin
            state    <= RUN;
            key_diff <= working_key ^ KEY;
            mode_q   <= mode;
            invert_q <= invert;
            row      <= '0;
            col      <= '0;
          end
        end
        RUN: begin
          if (xfer && last) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid || out_ready) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_stream_locked.sv
// Randomised self-checking bench for sobel_stream_locked against an image-level Sobel model.
// Two instances (8x6 and 16x16) share the stimulus; sel picks which one is exercised.
module tb_sobel_stream_locked;

  logic       clk = 1'b0;
  logic       rst_n, start, mode, invert, in_valid, out_ready, sel;
  logic [7:0] wkey, in_pix;

  logic       a_done, a_idle, a_rdy, a_in_ready, a_valid;
  logic [7:0] a_pix;
  logic       b_done, b_idle, b_rdy, b_in_ready, b_valid;
  logic [7:0] b_pix;

  logic       o_done, o_idle, o_rdy, o_in_ready, o_valid;
  logic [7:0] o_pix;

  int frame [256];
  int gw, gh, g_mask;
  bit g_keyok, g_mode, g_inv;
  int q [$];
  int hs_count, done_count, cyc, last_hs;
  int rdy_pct, vld_pct;
  int n_checks, n_fail;
  bit prev_stall;
  int prev_pix;

  always #5 clk = ~clk;

  sobel_stream_locked #(.IMG_W(8), .IMG_H(6), .PIX_W(8), .KEY_W(8), .KEY(8'hA5)) u_a (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start & !sel), .ap_done(a_done),
    .ap_idle(a_idle), .ap_ready(a_rdy), .working_key(wkey), .mode(mode), .invert(invert),
    .in_pix(in_pix), .in_valid(in_valid & !sel), .in_ready(a_in_ready),
    .out_pix(a_pix), .out_valid(a_valid), .out_ready(out_ready)
  );

  sobel_stream_locked #(.IMG_W(16), .IMG_H(16), .PIX_W(8), .KEY_W(8), .KEY(8'hA5)) u_b (
    .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(start & sel), .ap_done(b_done),
    .ap_idle(b_idle), .ap_ready(b_rdy), .working_key(wkey), .mode(mode), .invert(invert),
    .in_pix(in_pix), .in_valid(in_valid & sel), .in_ready(b_in_ready),
    .out_pix(b_pix), .out_valid(b_valid), .out_ready(out_ready)
  );

  assign o_done     = sel ? b_done     : a_done;
  assign o_idle     = sel ? b_idle     : a_idle;
  assign o_rdy      = sel ? b_rdy      : a_rdy;
  assign o_in_ready = sel ? b_in_ready : a_in_ready;
  assign o_valid    = sel ? b_valid    : a_valid;
  assign o_pix      = sel ? b_pix      : a_pix;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int px(input int y, input int x);
    return frame[y * gw + x];
  endfunction

  // Output for centre (y,x) computed directly from the image.
  function automatic int model(input int y, input int x);
    int gx, gy, ax, ay, mag;
    if (!g_keyok) return px(y, x) ^ (g_mask & 255);
    gx = (px(y-1, x+1) + 2*px(y, x+1) + px(y+1, x+1)) - (px(y-1, x-1) + 2*px(y, x-1) + px(y+1, x-1));
    gy = (px(y+1, x-1) + 2*px(y+1, x) + px(y+1, x+1)) - (px(y-1, x-1) + 2*px(y-1, x) + px(y-1, x+1));
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    mag = g_mode ? ((ax > ay) ? ax : ay) : (ax + ay);
    if (mag > 255) mag = 255;
    return g_inv ? 255 - mag : mag;
  endfunction

  task automatic fill(input int pat, input int w, input int h);
    gw = w;
    gh = h;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        case (pat)
          0: frame[y*w+x] = 50;
          1: frame[y*w+x] = (x < 4) ? 0 : 100;
          2: frame[y*w+x] = (x < 4) ? 0 : 20;
          3: frame[y*w+x] = (y < 3) ? 0 : 20;
          default: frame[y*w+x] = int'($urandom_range(255));
        endcase
  endtask

  task automatic set_cfg(input logic [7:0] k, input bit md, input bit inv);
    wkey    = k;
    mode    = md;
    invert  = inv;
    g_keyok = (k == 8'hA5);
    g_mask  = int'(k ^ 8'hA5);
    g_mode  = md;
    g_inv   = inv;
  endtask

  // Runs one frame; with abort_at>0 it returns right after that many transfers.
  task automatic run_frame(input int abort_at);
    int idx, guard;
    bit xfer;
    idx = 0;
    guard = 0;
    q.delete();
    for (int y = 1; y < gh - 1; y++)
      for (int x = 1; x < gw - 1; x++)
        q.push_back(model(y, x));
    hs_count = 0;
    done_count = 0;
    in_valid = 1'b1;
    in_pix = 8'd7;
    @(negedge clk);
    check("idle_in_ready", int'(o_in_ready), 0);
    check("idle_flag", int'(o_idle), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("run_not_idle", int'(o_idle), 0);
    while (idx < gw * gh && guard < 20000) begin
      in_valid = ($urandom_range(99) < vld_pct);
      in_pix = 8'(frame[idx]);
      @(negedge clk);
      xfer = in_valid && o_in_ready;
      @(posedge clk); #1;
      guard++;
      if (xfer) begin
        idx++;
        if (idx == abort_at) break;
      end
    end
    in_valid = 1'b0;
    if (abort_at > 0) return;
    check("all_pixels_in", idx, gw * gh);
    guard = 0;
    while (done_count == 0 && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", done_count, 1);
    check("out_count", hs_count, (gw - 2) * (gh - 2));
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Output compare: value/order, stall stability and ap_done timing.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", int'(o_valid), 1);
        check("stall_pix", int'(o_pix), prev_pix);
      end
      if (o_valid && out_ready) begin
        if (q.size() == 0) check("extra_output", 1, 0);
        else check("out_pix", int'(o_pix), q.pop_front());
        hs_count++;
        last_hs = cyc;
      end
      if (o_done) begin
        done_count++;
        check("done_timing", cyc, last_hs + 1);
        check("ready_eq_done", int'(o_rdy), 1);
      end
      prev_stall = o_valid && !out_ready;
      prev_pix = int'(o_pix);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_pix = '0; sel = 1'b0;
    wkey = '0; mode = 1'b0; invert = 1'b0;
    rdy_pct = 100; vld_pct = 100;
    n_checks = 0; n_fail = 0; cyc = 0; last_hs = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", int'(o_valid), 0);
    check("rst_pix", int'(o_pix), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_idle", int'(o_idle), 1);
    rst_n = 1'b1;

    fill(0, 8, 6); set_cfg(8'hA5, 1'b0, 1'b1);
    check("pin_const", model(2, 3), 255);
    run_frame(0);

    vld_pct = 70;
    fill(1, 8, 6);
    check("pin_vstep_edge", model(2, 3), 0);
    check("pin_vstep_flat", model(2, 2), 255);
    run_frame(0);

    set_cfg(8'hA5, 1'b0, 1'b0); fill(2, 8, 6);
    check("pin_step20", model(1, 4), 80);
    run_frame(0);
    set_cfg(8'hA5, 1'b1, 1'b0);
    check("pin_step20_max", model(1, 3), 80);
    run_frame(0);
    set_cfg(8'hA5, 1'b0, 1'b0); fill(3, 8, 6);
    check("pin_hstep_edge", model(2, 1), 80);
    check("pin_hstep_flat", model(1, 1), 0);
    run_frame(0);

    sel = 1'b1; rdy_pct = 50; vld_pct = 70;
    fill(4, 16, 16); set_cfg(8'hA5, $urandom_range(1) == 1, $urandom_range(1) == 1);
    run_frame(0);
    sel = 1'b0;

    rdy_pct = 100; vld_pct = 100;
    fill(0, 8, 6); set_cfg(8'hA4, 1'b0, 1'b1);
    check("pin_badkey", model(2, 2), 51);
    run_frame(0);

    rdy_pct = 50; vld_pct = 80;
    fill(4, 8, 6); set_cfg(8'hA5, 1'b0, 1'b0);
    run_frame(20);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_valid", int'(o_valid), 0);
    check("abort_pix", int'(o_pix), 0);
    check("abort_done", int'(o_done), 0);
    check("abort_in_ready", int'(o_in_ready), 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_rst_idle", int'(o_idle), 1);
    fill(4, 8, 6); set_cfg(8'hA5, 1'b1, 1'b1);
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
